// File: rtl/add_arbiter.sv
// add_arbiter: round-robin access to one shared 32-bit carry-lookahead adder,
// with a single registered response slot tagged by requester index.

module add_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    localparam int unsigned NGRP = 8;

    // 4-bit lookahead groups; group carries chain through group generate/propagate
    function automatic logic [32:0] cla32(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci);
        logic [31:0]     g;
        logic [31:0]     p;
        logic [31:0]     c;
        logic [NGRP-1:0] gg;
        logic [NGRP-1:0] gp;
        logic [NGRP:0]   gc;
        g = x & y;
        p = x ^ y;
        for (int k = 0; k < NGRP; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        gc[0] = ci;
        for (int k = 0; k < NGRP; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < NGRP; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        return {gc[NGRP], p ^ c};
    endfunction

    always_comb begin
        {cout, sum} = cla32(a, b, cin);
    end
endmodule

module add_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_sum,
    output logic               rsp_carry,
    output logic               busy
);
    localparam int unsigned DW = 32;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [DW-1:0]  sum_q, sum_d;
    logic           carry_q, carry_d;

    logic           slot_free;
    logic           accept;
    logic           cand_found;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] scan_idx;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;
    logic [DW-1:0]  add_sum;
    logic           add_cout;

    // First valid requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((32'(ptr_q) + k) % NREQ);
            if (!cand_found && req_valid[scan_idx]) begin
                cand_found = 1'b1;
                cand       = scan_idx;
            end
        end
    end

    // Grant depends only on valids, response handshake and state, never on operands
    always_comb begin
        slot_free = (state_q == ST_IDLE) || rsp_ready;
        accept    = rst_n && slot_free && cand_found;
        req_ready = '0;
        if (accept) begin
            req_ready[cand] = 1'b1;
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (cand == IDW'(k)) begin
                op_a = req_a[DW*k +: DW];
                op_b = req_b[DW*k +: DW];
            end
        end
    end

    add_cla u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // An accept reloads the slot even while the previous response is being taken
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                if (accept) begin
                    state_d = ST_HOLD;
                end else if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (accept) begin
            ptr_d   = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
            id_d    = cand;
            sum_d   = add_sum;
            carry_d = add_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign rsp_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_HOLD);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_stall_no_grant: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_HOLD && !rsp_ready) |-> (req_ready == '0));
endmodule
